// File: rtl/pipelined_control.sv
// Pipelined main control: decodes the ID-stage opcode into EX/M/WB bundles and carries them through ID/EX, EX/MEM and MEM/WB.
// Optional saturating illegal-opcode counter is enabled with the PCTRL_ILLCNT_EN macro.
module pipelined_control #(
  parameter int          OPCODE_W  = 6,
  parameter logic        DC_VAL    = 1'b0,
  parameter bit          ADDI_EN   = 1'b1,
  parameter int          ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 stall,
  input  logic                 flush,
  output logic [3:0]           ex_ctrl,
  output logic [2:0]           m_ctrl,
  output logic [1:0]           wb_ctrl,
`ifdef PCTRL_ILLCNT_EN
  output logic [ILL_CNT_W-1:0] ill_count,
`endif
  output logic                 illegal_op
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(6'b100000);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);

  logic [3:0] dec_ex;
  logic [2:0] dec_m;
  logic [1:0] dec_wb;
  logic       dec_ill;

  always_comb begin
    dec_ex  = 4'b0000;
    dec_m   = 3'b000;
    dec_wb  = 2'b00;
    dec_ill = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        dec_ex = 4'b1100;
        dec_wb = 2'b10;
      end
      OP_LW: begin
        dec_ex = 4'b0001;
        dec_m  = 3'b010;
        dec_wb = 2'b11;
      end
      OP_SW: begin
        dec_ex = {DC_VAL, 3'b001};
        dec_m  = 3'b001;
        dec_wb = {1'b0, DC_VAL};
      end
      OP_BEQ: begin
        dec_ex = {DC_VAL, 3'b010};
        dec_m  = 3'b100;
        dec_wb = {1'b0, DC_VAL};
      end
      OP_NOP: begin
        dec_ex = 4'b0000;
      end
      OP_ADDI: begin
        if (ADDI_EN) begin
          dec_ex = 4'b0001;
          dec_wb = 2'b10;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // ID/EX
  logic [3:0] idex_ex_q, idex_ex_d;
  logic [2:0] idex_m_q, idex_m_d;
  logic [1:0] idex_wb_q, idex_wb_d;
  logic       idex_ill_q, idex_ill_d;
  // EX/MEM
  logic [2:0] exmem_m_q, exmem_m_d;
  logic [1:0] exmem_wb_q, exmem_wb_d;
  // MEM/WB
  logic [1:0] memwb_wb_q, memwb_wb_d;

  logic bubble;
  assign bubble = stall | flush;

  always_comb begin
    idex_ex_d  = bubble ? 4'b0000 : dec_ex;
    idex_m_d   = bubble ? 3'b000  : dec_m;
    idex_wb_d  = bubble ? 2'b00   : dec_wb;
    idex_ill_d = bubble ? 1'b0    : dec_ill;
    // Flush also kills the bundle already in EX (the wrong-path instruction).
    exmem_m_d  = flush ? 3'b000 : idex_m_q;
    exmem_wb_d = flush ? 2'b00  : idex_wb_q;
    memwb_wb_d = exmem_wb_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_ex_q  <= 4'b0000;
      idex_m_q   <= 3'b000;
      idex_wb_q  <= 2'b00;
      idex_ill_q <= 1'b0;
      exmem_m_q  <= 3'b000;
      exmem_wb_q <= 2'b00;
      memwb_wb_q <= 2'b00;
    end else begin
      idex_ex_q  <= idex_ex_d;
      idex_m_q   <= idex_m_d;
      idex_wb_q  <= idex_wb_d;
      idex_ill_q <= idex_ill_d;
      exmem_m_q  <= exmem_m_d;
      exmem_wb_q <= exmem_wb_d;
      memwb_wb_q <= memwb_wb_d;
    end
  end

  assign ex_ctrl    = idex_ex_q;
  assign illegal_op = idex_ill_q;
  assign m_ctrl     = exmem_m_q;
  assign wb_ctrl    = memwb_wb_q;

`ifdef PCTRL_ILLCNT_EN
  localparam logic [ILL_CNT_W-1:0] ILL_MAX = {ILL_CNT_W{1'b1}};

  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  // Counts only opcodes that actually land in ID/EX; saturates rather than wrapping.
  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (dec_ill && !bubble && (ill_cnt_q != ILL_MAX)) begin
      ill_cnt_d = ill_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ill_cnt_q <= '0;
    end else begin
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign ill_count = ill_cnt_q;
`endif

endmodule
